// File: rtl/frame_rx_checker.sv
// Ethernet receive checker: preamble/SFD sync, header extraction, payload strip, FCS and length check.
// Header 1 cycle after byte 13, payload 1 cycle after its displacement from a 4-byte FCS delay line, status 1 cycle after tx_en falls; no backpressure.
module frame_rx_checker #(
   parameter int MAX_FRAME = 1518,
   parameter int MIN_FRAME = 18
) (
   input  logic        txc,
   input  logic        rst,
   input  logic        tx_en,
   input  logic [7:0]  txd,
   output logic        hdr_vld,
   output logic [47:0] dmac,
   output logic [47:0] smac,
   output logic [15:0] ether_type,
   output logic        pld_vld,
   output logic [7:0]  pld_data,
   output logic        frm_done,
   output logic        frm_ok,
   output logic [3:0]  frm_err,
   output logic [10:0] frm_len,
   output logic [15:0] good_cnt,
   output logic [15:0] bad_cnt
);

   typedef enum logic [1:0] {IDLE, PREAMBLE, BODY, DROP} state_t;

   localparam logic [10:0] MIN_L = MIN_FRAME[10:0];
   localparam logic [10:0] MAX_L = MAX_FRAME[10:0];
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   state_t          state;
   logic            armed;
   logic [2:0]      pre_cnt;
   logic [10:0]     len;
   logic [31:0]     crc;
   logic [3:0][7:0] dly;
   logic            sync_err;
   logic [3:0]      end_err;

   function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Status presented when tx_en drops; runt masks the CRC verdict.
   always_comb begin
      end_err = 4'b0000;
      if (state == BODY) begin
         end_err[3] = (len > MAX_L);
         end_err[1] = (len < MIN_L);
         end_err[2] = (len >= MIN_L) && (crc != CRC_RESIDUE);
      end else begin
         end_err[0] = sync_err || (state == PREAMBLE);
      end
   end

   always_ff @(posedge txc or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         armed      <= 1'b0;
         pre_cnt    <= 3'd0;
         len        <= 11'd0;
         crc        <= 32'hFFFFFFFF;
         dly        <= '0;
         sync_err   <= 1'b0;
         hdr_vld    <= 1'b0;
         dmac       <= 48'h0;
         smac       <= 48'h0;
         ether_type <= 16'h0;
         pld_vld    <= 1'b0;
         pld_data   <= 8'h0;
         frm_done   <= 1'b0;
         frm_ok     <= 1'b0;
         frm_err    <= 4'h0;
         frm_len    <= 11'd0;
         good_cnt   <= 16'h0;
         bad_cnt    <= 16'h0;
      end else begin
         hdr_vld  <= 1'b0;
         pld_vld  <= 1'b0;
         frm_done <= 1'b0;
         // A frame cut by reset is ignored until tx_en has been seen low.
         if (!tx_en)
            armed <= 1'b1;

         if (state != IDLE && !tx_en) begin
            frm_done <= 1'b1;
            frm_err  <= end_err;
            frm_ok   <= (end_err == 4'b0000);
            frm_len  <= len;
            if (end_err == 4'b0000) begin
               if (good_cnt != 16'hFFFF)
                  good_cnt <= good_cnt + 16'd1;
            end else if (bad_cnt != 16'hFFFF) begin
               bad_cnt <= bad_cnt + 16'd1;
            end
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (tx_en && armed) begin
                     len <= 11'd0;
                     pre_cnt <= 3'd1;
                     if (txd == 8'h55) begin
                        sync_err <= 1'b0;
                        state    <= PREAMBLE;
                     end else begin
                        sync_err <= 1'b1;
                        state    <= DROP;
                     end
                  end
               end
               PREAMBLE: begin
                  if (txd == 8'hD5) begin
                     crc   <= 32'hFFFFFFFF;
                     state <= BODY;
                  end else if (txd == 8'h55 && pre_cnt != 3'd7) begin
                     pre_cnt <= pre_cnt + 3'd1;
                  end else begin
                     sync_err <= 1'b1;
                     state    <= DROP;
                  end
               end
               BODY: begin
                  if (len != 11'h7FF)
                     len <= len + 11'd1;
                  crc <= crc_next(crc, txd);
                  dly <= {dly[2:0], txd};
                  if (len < 11'd6)
                     dmac <= {dmac[39:0], txd};
                  else if (len < 11'd12)
                     smac <= {smac[39:0], txd};
                  else if (len < 11'd14)
                     ether_type <= {ether_type[7:0], txd};
                  if (len == 11'd13)
                     hdr_vld <= 1'b1;
                  // dly[3] holds byte len-4; it is payload once that index reaches 14.
                  if (len >= 11'd18) begin
                     pld_vld  <= 1'b1;
                     pld_data <= dly[3];
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frame_rx_checker.sv
// Directed bench for frame_rx_checker: good, CRC, runt, sync, reset-abort, back-to-back and long frames.
module tb_frame_rx_checker;

   logic        txc = 1'b0;
   logic        rst = 1'b1;
   logic        tx_en = 1'b0;
   logic [7:0]  txd = 8'h00;
   logic        hdr_vld, pld_vld, frm_done, frm_ok;
   logic [47:0] dmac, smac;
   logic [15:0] ether_type, good_cnt, bad_cnt;
   logic [7:0]  pld_data;
   logic [3:0]  frm_err;
   logic [10:0] frm_len;

   int checks = 0;
   int failures = 0;

   int hdr_cnt = 0;
   int done_cnt = 0;
   logic [7:0] pld_q[$];
   logic [7:0] frm_q[$];

   frame_rx_checker #(.MAX_FRAME(1518), .MIN_FRAME(18)) dut (
      .txc(txc), .rst(rst), .tx_en(tx_en), .txd(txd),
      .hdr_vld(hdr_vld), .dmac(dmac), .smac(smac), .ether_type(ether_type),
      .pld_vld(pld_vld), .pld_data(pld_data),
      .frm_done(frm_done), .frm_ok(frm_ok), .frm_err(frm_err), .frm_len(frm_len),
      .good_cnt(good_cnt), .bad_cnt(bad_cnt)
   );

   always #5 txc = ~txc;

   always @(negedge txc) begin
      if (hdr_vld) hdr_cnt++;
      if (pld_vld) pld_q.push_back(pld_data);
      if (frm_done) done_cnt++;
   end

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Preamble, SFD, fixed header, payload i[7:0], FCS; optional bit flip after FCS is computed.
   task automatic build_frame(input int npay, input bit flip);
      logic [7:0] body[$];
      logic [47:0] da;
      logic [47:0] sa;
      logic [31:0] c;
      da = 48'h001122334455;
      sa = 48'h66778899AABB;
      body = {};
      for (int i = 5; i >= 0; i--) body.push_back(da[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) body.push_back(sa[i*8 +: 8]);
      body.push_back(8'h08);
      body.push_back(8'h00);
      for (int i = 0; i < npay; i++) body.push_back(i[7:0]);
      c = 32'hFFFFFFFF;
      foreach (body[i]) c = crc_byte(c, body[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) body.push_back(c[i*8 +: 8]);
      if (flip) body[19] = body[19] ^ 8'h01;
      frm_q = {};
      for (int i = 0; i < 7; i++) frm_q.push_back(8'h55);
      frm_q.push_back(8'hD5);
      foreach (body[i]) frm_q.push_back(body[i]);
   endtask

   task automatic drive_frame();
      foreach (frm_q[i]) begin
         @(posedge txc); #1;
         tx_en = 1'b1;
         txd = frm_q[i];
      end
      @(posedge txc); #1;
      tx_en = 1'b0;
      txd = 8'h00;
   endtask

   task automatic wait_done(input int target, input string name);
      for (int i = 0; i < 40; i++) begin
         if (done_cnt >= target) break;
         @(negedge txc);
      end
      checks++;
      if (done_cnt < target) begin
         failures++;
         $display("FAIL %s_timeout done=%0d required=%0d", name, done_cnt, target);
      end
      @(negedge txc);
   endtask

   task automatic apply_reset();
      #1 rst = 1'b1;
      tx_en = 1'b0;
      repeat (2) @(posedge txc);
      #1 rst = 1'b0;
      @(negedge txc);
   endtask

   task automatic check_pld(input int p0, input int n, input string name);
      int bad;
      bad = 0;
      checks++;
      if (pld_q.size() - p0 !== n) begin
         failures++;
         $display("FAIL %s_pld_count got=%0d exp=%0d", name, pld_q.size() - p0, n);
      end else begin
         for (int i = 0; i < n; i++)
            if (pld_q[p0 + i] !== i[7:0]) bad++;
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL %s_pld_data mismatched_bytes=%0d exp=0", name, bad);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge txc);
      checks++;
      if ({hdr_vld, pld_vld, frm_done, frm_ok} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_pulses got=%b exp=0000", {hdr_vld, pld_vld, frm_done, frm_ok});
      end
      checks++;
      if ({dmac, smac, ether_type} !== 112'h0) begin
         failures++;
         $display("FAIL reset_hdr got=%h exp=0", {dmac, smac, ether_type});
      end
      checks++;
      if ({frm_err, frm_len, pld_data} !== 23'h0 || {good_cnt, bad_cnt} !== 32'h0) begin
         failures++;
         $display("FAIL reset_status got=%h/%h exp=0", {frm_err, frm_len, pld_data}, {good_cnt, bad_cnt});
      end
      #1 rst = 1'b0;
      @(negedge txc);
   endtask

   task automatic test_good();
      int h0, d0, p0;
      h0 = hdr_cnt; d0 = done_cnt; p0 = pld_q.size();
      build_frame(46, 1'b0);
      drive_frame();
      wait_done(d0 + 1, "good");
      checks++;
      if (hdr_cnt - h0 !== 1) begin failures++; $display("FAIL good_hdr_vld got=%0d exp=1", hdr_cnt - h0); end
      checks++;
      if (dmac !== 48'h001122334455) begin failures++; $display("FAIL good_dmac got=%h exp=001122334455", dmac); end
      checks++;
      if (smac !== 48'h66778899AABB) begin failures++; $display("FAIL good_smac got=%h exp=66778899aabb", smac); end
      checks++;
      if (ether_type !== 16'h0800) begin failures++; $display("FAIL good_type got=%h exp=0800", ether_type); end
      check_pld(p0, 46, "good");
      checks++;
      if (frm_ok !== 1'b1 || frm_err !== 4'b0000) begin failures++; $display("FAIL good_status ok=%b err=%b exp ok=1 err=0000", frm_ok, frm_err); end
      checks++;
      if (frm_len !== 11'd64) begin failures++; $display("FAIL good_len got=%0d exp=64", frm_len); end
      checks++;
      if (good_cnt !== 16'd1 || bad_cnt !== 16'd0) begin failures++; $display("FAIL good_cnt got=%0d/%0d exp=1/0", good_cnt, bad_cnt); end
      checks++;
      if (done_cnt - d0 !== 1) begin failures++; $display("FAIL good_done_pulses got=%0d exp=1", done_cnt - d0); end
   endtask

   task automatic test_crc_err();
      int d0, p0;
      d0 = done_cnt; p0 = pld_q.size();
      build_frame(46, 1'b1);
      drive_frame();
      wait_done(d0 + 1, "crc");
      checks++;
      if (pld_q.size() - p0 !== 46) begin failures++; $display("FAIL crc_pld_count got=%0d exp=46", pld_q.size() - p0); end
      checks++;
      if (frm_err !== 4'b0100 || frm_ok !== 1'b0) begin failures++; $display("FAIL crc_err got=%b ok=%b exp=0100 ok=0", frm_err, frm_ok); end
      checks++;
      if (bad_cnt !== 16'd1) begin failures++; $display("FAIL crc_bad_cnt got=%0d exp=1", bad_cnt); end
   endtask

   task automatic test_runt();
      int h0, d0, p0;
      h0 = hdr_cnt; d0 = done_cnt; p0 = pld_q.size();
      frm_q = {8'h55, 8'hD5};
      for (int i = 0; i < 10; i++) frm_q.push_back(8'hA0 + i[7:0]);
      drive_frame();
      wait_done(d0 + 1, "runt");
      checks++;
      if (hdr_cnt - h0 !== 0 || pld_q.size() - p0 !== 0) begin
         failures++; $display("FAIL runt_strobes hdr=%0d pld=%0d exp=0/0", hdr_cnt - h0, pld_q.size() - p0);
      end
      checks++;
      if (frm_err !== 4'b0010) begin failures++; $display("FAIL runt_err got=%b exp=0010", frm_err); end
      checks++;
      if (frm_len !== 11'd10) begin failures++; $display("FAIL runt_len got=%0d exp=10", frm_len); end
   endtask

   task automatic test_sync();
      int h0, d0;
      h0 = hdr_cnt; d0 = done_cnt;
      frm_q = {8'h55, 8'h55, 8'hA5};
      for (int i = 0; i < 20; i++) frm_q.push_back(i[7:0]);
      drive_frame();
      wait_done(d0 + 1, "sync");
      checks++;
      if (hdr_cnt - h0 !== 0) begin failures++; $display("FAIL sync_hdr got=%0d exp=0", hdr_cnt - h0); end
      checks++;
      if (frm_err !== 4'b0001 || frm_ok !== 1'b0) begin failures++; $display("FAIL sync_err got=%b ok=%b exp=0001 ok=0", frm_err, frm_ok); end
      checks++;
      if (bad_cnt !== 16'd3) begin failures++; $display("FAIL sync_bad_cnt got=%0d exp=3", bad_cnt); end
   endtask

   task automatic test_reset_mid_frame();
      int d0;
      d0 = done_cnt;
      build_frame(46, 1'b0);
      foreach (frm_q[i]) begin
         @(posedge txc); #1;
         tx_en = 1'b1;
         txd = frm_q[i];
         rst = (i == 28);
      end
      @(posedge txc); #1;
      tx_en = 1'b0;
      repeat (10) @(negedge txc);
      checks++;
      if (done_cnt - d0 !== 0) begin failures++; $display("FAIL rstmid_done got=%0d exp=0", done_cnt - d0); end
      checks++;
      if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", good_cnt, bad_cnt); end
      d0 = done_cnt;
      drive_frame();
      wait_done(d0 + 1, "rstmid");
      checks++;
      if (frm_ok !== 1'b1 || good_cnt !== 16'd1) begin failures++; $display("FAIL rstmid_second ok=%b good=%0d exp ok=1 good=1", frm_ok, good_cnt); end
   endtask

   task automatic test_back_to_back();
      int d0, p0;
      apply_reset();
      d0 = done_cnt; p0 = pld_q.size();
      build_frame(46, 1'b0);
      drive_frame();
      drive_frame();
      wait_done(d0 + 2, "b2b");
      checks++;
      if (good_cnt !== 16'd2 || bad_cnt !== 16'd0) begin failures++; $display("FAIL b2b_cnt got=%0d/%0d exp=2/0", good_cnt, bad_cnt); end
      checks++;
      if (pld_q.size() - p0 !== 92) begin failures++; $display("FAIL b2b_pld_count got=%0d exp=92", pld_q.size() - p0); end
      d0 = done_cnt; p0 = pld_q.size();
      build_frame(1582, 1'b0);
      drive_frame();
      wait_done(d0 + 1, "long");
      checks++;
      if (frm_err !== 4'b1000) begin failures++; $display("FAIL long_err got=%b exp=1000", frm_err); end
      checks++;
      if (frm_len !== 11'd1600) begin failures++; $display("FAIL long_len got=%0d exp=1600", frm_len); end
      check_pld(p0, 1582, "long");
      checks++;
      if (good_cnt !== 16'd2 || bad_cnt !== 16'd1) begin failures++; $display("FAIL long_cnt got=%0d/%0d exp=2/1", good_cnt, bad_cnt); end
   endtask

   initial begin
      test_reset();
      test_good();
      test_crc_err();
      test_runt();
      test_sync();
      test_reset_mid_frame();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frame_rx_checker.md
FRAME_RX_CHECKER -- requirements
Module: frame_rx_checker

Interface
REQ-001 SHALL have parameter MAX_FRAME, default 1518: maximum legal bytes after SFD (dmac through FCS inclusive).
REQ-002 SHALL have parameter MIN_FRAME, default 18: minimum legal bytes after SFD (14-byte header plus 4-byte FCS).
REQ-003 SHALL have port txc  input  1  clock; the single clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port tx_en  input  1  byte-valid of the byte stream under check; high for a whole frame.
REQ-006 SHALL have port txd  input  8  byte data, sampled when tx_en=1.
REQ-007 SHALL have port hdr_vld  output  1  one-cycle pulse; dmac/smac/ether_type are valid.
REQ-008 SHALL have port dmac  output  48  destination MAC; first received byte in [47:40].
REQ-009 SHALL have port smac  output  48  source MAC; first received byte in [47:40].
REQ-010 SHALL have port ether_type  output  16  type field; first received byte in [15:8].
REQ-011 SHALL have port pld_vld  output  1  payload byte strobe.
REQ-012 SHALL have port pld_data  output  8  payload byte; FCS bytes are never emitted.
REQ-013 SHALL have port frm_done  output  1  one-cycle end-of-frame status pulse.
REQ-014 SHALL have port frm_ok  output  1  valid with frm_done; 1 when frm_err==0.
REQ-015 SHALL have port frm_err  output  4  valid with frm_done; {long, crc, runt, sync}.
REQ-016 SHALL have port frm_len  output  11  valid with frm_done; bytes after SFD, saturating at 2047.
REQ-017 SHALL have port good_cnt  output  16  count of frames ending with frm_ok=1, saturating.
REQ-018 SHALL have port bad_cnt  output  16  count of frames ending with frm_ok=0, saturating.

Function
REQ-019 SHALL implement states IDLE, PREAMBLE, BODY, DROP.
REQ-020 IDLE: tx_en=1 with txd=0x55 -> PREAMBLE; any other byte -> DROP with sync flag set.
REQ-021 PREAMBLE: 0x55 stays, up to 7 total; 0xD5 -> BODY; any other byte or an 8th 0x55 -> DROP with sync set; tx_en=0 -> frm_done with sync set, then IDLE.
REQ-022 DROP: bytes are ignored; tx_en=0 -> frm_done with the flags held, then IDLE.
REQ-023 BODY: each byte increments the length counter; byte indices 0-5 load dmac, 6-11 load smac, 12-13 load ether_type.
REQ-024 hdr_vld SHALL pulse on the cycle after byte 13 is sampled; dmac, smac and ether_type hold until the next frame's header overwrites them.
REQ-025 BODY bytes SHALL pass through a 4-byte delay line.
REQ-026 When an incoming byte displaces a byte of index >=14, that byte SHALL appear on pld_data with pld_vld=1 on the following cycle.
REQ-027 The 4 bytes left in the delay line at tx_en=0 are the FCS and SHALL be discarded.
REQ-028 CRC-32: polynomial 0x04C11DB7, reflected, LSB-first, initialised to 0xFFFFFFFF at SFD, run over every BODY byte including the FCS.
REQ-029 The crc flag SHALL be set if the register differs from 0xDEBB20E3 at end of frame and length >= MIN_FRAME.
REQ-030 The runt flag SHALL be set if length < MIN_FRAME; the crc flag is then not evaluated.
REQ-031 The long flag SHALL be set if length > MAX_FRAME; reception and CRC continue to the end of the frame.
REQ-032 End of frame: on the first cycle tx_en=0 is sampled in BODY, frm_done/frm_ok/frm_err/frm_len SHALL be driven on the next cycle.
REQ-033 Counters SHALL update in the same cycle as frm_done and saturate at 0xFFFF.
REQ-034 A frame starting on the cycle directly after tx_en falls SHALL be received correctly; status and pipeline of the previous frame must not corrupt it.
REQ-035 Pulses hdr_vld, pld_vld and frm_done SHALL be exactly one cycle wide per event.

Reset
REQ-036 On rst=1, state SHALL be IDLE and every output, counter, delay line and flag SHALL be 0; CRC register 0xFFFFFFFF.
REQ-037 On reset mid-frame, the partial frame SHALL be discarded with no frm_done, and reception SHALL restart on the next tx_en rising edge after rst=0.

Verification
REQ-038 Good frame: 7x0x55, 0xD5, dmac 001122334455, smac 66778899AABB, type 0x0800, payload 0x00..0x2D, valid FCS -> hdr_vld with those values, 46 pld bytes in order, frm_ok=1, frm_len=64, good_cnt=1.
REQ-039 Same frame with payload byte 5 bit 0 flipped -> 46 pld bytes, frm_err=4'b0100, bad_cnt=1.
REQ-040 0x55, 0xD5, then 10 bytes, tx_en low -> no hdr_vld, no pld_vld, frm_err=4'b0010, frm_len=10.
REQ-041 0x55,0x55,0xA5,... -> no hdr_vld, frm_err=4'b0001 at tx_en fall.
REQ-042 Reset pulse at BODY byte 20, then a good frame -> no frm_done for the first frame; the second gives frm_ok=1 and good_cnt=1.
REQ-043 Two good frames separated by one idle cycle, plus a 1600-byte frame -> good_cnt=2, then frm_err=4'b1000, frm_len=1600.
